// File: rtl/data_mem_pkg.sv
// Shared types for the CPU-side data memory master: FSM states, widths and
// access-size encodings.
package data_mem_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef enum logic {
    SZ_WORD = 1'b0,
    SZ_BYTE = 1'b1
  } size_t;

  // Latched request; the operation itself (load / word store / byte store)
  // is carried by the FSM state, and store data lives in the write word.
  typedef struct packed {
    size_t         size;
    logic          hi;
    logic          sgn;
    logic [DW-1:0] addr;
  } req_t;

  function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(DW-8){sgn & b[7]}}, b};
  endfunction

endpackage

// File: rtl/data_mem_master_byte_lane_unit.sv
// Combinational byte-lane datapath: load extraction with sign/zero extend,
// and byte merge into a read word for read-modify-write stores.
module byte_lane_unit
  import data_mem_pkg::*;
(
  input  logic [DW-1:0] rdata,
  input  size_t         size,
  input  logic          hi,
  input  logic          sgn,
  input  logic [7:0]    wbyte,
  output logic [DW-1:0] load_data,
  output logic [DW-1:0] merge_data
);

  logic [7:0] lane;

  always_comb begin
    lane       = hi ? rdata[DW-1:8] : rdata[7:0];
    load_data  = (size == SZ_BYTE) ? ext8(lane, sgn) : rdata;
    merge_data = hi ? {wbyte, rdata[7:0]} : {rdata[DW-1:8], wbyte};
  end

endmodule

// File: rtl/data_mem_master.sv
// CPU load/store front end to a 16-bit word memory with combinational read;
// byte stores are done as a read-modify-write of the containing word.
module data_mem_master
  import data_mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic          req_hi,
  input  logic          req_signed,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic [DW-1:0] addrM,
  output logic [DW-1:0] write_dataM,
  output logic          write_en,
  input  logic [DW-1:0] read_dataM
);

  state_t        state;
  req_t          req_q;
  logic [DW-1:0] wword;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merge_data;

  byte_lane_unit u_lane (
    .rdata      (read_dataM),
    .size       (req_q.size),
    .hi         (req_q.hi),
    .sgn        (req_q.sgn),
    .wbyte      (wword[7:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Memory-side outputs are pure decodes of registered state, so they never
  // carry stale values into IDLE/RESP; write_en is also masked by reset.
  always_comb begin
    addrM       = '0;
    write_dataM = '0;
    write_en    = 1'b0;
    if (state == LOAD || state == RMW_RD || state == WRITE)
      addrM = req_q.addr;
    if (state == WRITE) begin
      write_dataM = wword;
      write_en    = ~reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      wword      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q.size <= req_byte ? SZ_BYTE : SZ_WORD;
            req_q.hi   <= req_hi;
            req_q.sgn  <= req_signed;
            req_q.addr <= req_addr;
            wword      <= req_wdata;
            req_ready  <= 1'b0;
            if (!req_we)       state <= LOAD;
            else if (req_byte) state <= RMW_RD;
            else               state <= WRITE;
          end
        end
        LOAD: begin
          resp_data  <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          wword <= merge_data;
          state <= WRITE;
        end
        WRITE: begin
          resp_data  <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // req_ready rises only after the handshake edge, so a new request
          // can never be taken in the same cycle as the response.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a word-memory model and an
// in-order response scoreboard.
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_byte, req_hi, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data, addrM, write_dataM, read_dataM;
  logic        write_en;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          resp_cnt = 0;
  logic [15:0] last_wdata, last_waddr;

  always #5 clk = ~clk;

  data_mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_hi(req_hi), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .addrM(addrM), .write_dataM(write_dataM), .write_en(write_en),
    .read_dataM(read_dataM)
  );

  assign read_dataM = mem[addrM];

  always @(posedge clk) if (write_en) mem[addrM] <= write_dataM;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write strobe and response monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_en) begin
      we_cnt++;
      last_wdata = write_dataM;
      last_waddr = addrM;
    end
    if (reset) chk("we_in_reset", write_en, 1'b0);
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 1'b0);
      else chk("resp_data", resp_data, exp_q.pop_front());
      resp_cnt++;
    end
  end

  task automatic send(input logic we, input logic byt, input logic hi, input logic sgn,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp, output int lat);
    int g;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_byte = byt; req_hi = hi;
    req_signed = sgn; req_addr = addr; req_wdata = wdata;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept", req_ready, 1'b1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk("idle", req_ready, 1'b1);
  endtask

  initial begin
    int lat, w0, r0, n, busy;
    logic rdy_ok;
    for (int i = 0; i < 65536; i++) mem[i] = i[15:0];
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_hi = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 16'h0);
    chk("rst_addrM", addrM, 16'h0);
    chk("rst_wdataM", write_dataM, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Word load, hi/signed ignored in the second one
    w0 = we_cnt;
    send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0, 16'h0012, lat);
    chk("lat_wload", lat, 2);
    wait_idle();
    chk("wload_no_we", we_cnt, w0);
    send(1'b0, 1'b0, 1'b1, 1'b1, 16'h8034, 16'h0, 16'h8034, lat);
    chk("lat_wload2", lat, 2);
    wait_idle();

    // Byte loads of the high lane at 0x8034 (0x80)
    send(1'b0, 1'b1, 1'b1, 1'b1, 16'h8034, 16'h0, 16'hFF80, lat);
    chk("lat_bload_s", lat, 2);
    wait_idle();
    send(1'b0, 1'b1, 1'b1, 1'b0, 16'h8034, 16'h0, 16'h0080, lat);
    chk("lat_bload_u", lat, 2);
    wait_idle();
    send(1'b0, 1'b1, 1'b0, 1'b1, 16'h0045, 16'h0, 16'h0045, lat);
    wait_idle();

    // Byte store low lane; upper wdata bits must be ignored
    w0 = we_cnt;
    send(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h55AB, 16'h0000, lat);
    chk("lat_bstore", lat, 3);
    wait_idle();
    chk("bstore_we_cnt", we_cnt, w0 + 1);
    chk("bstore_wdataM", last_wdata, 16'h01AB);
    chk("bstore_addrM", last_waddr, 16'h0100);
    chk("bstore_mem", mem[16'h0100], 16'h01AB);

    // Byte store high lane
    send(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h00CD, 16'h0000, lat);
    chk("lat_bstore_hi", lat, 3);
    wait_idle();
    chk("bstore_hi_mem", mem[16'h0005], 16'hCD05);

    // Word store at 0xFFFF with resp_ready low for 3 cycles
    resp_ready = 1'b0;
    w0 = we_cnt;
    send(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 16'h0000, lat);
    chk("lat_wstore", lat, 2);
    n = 0; rdy_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) n++;
      if (req_ready) rdy_ok = 1'b0;
      @(posedge clk); #1;
      if (i == 2) resp_ready = 1'b1;
      @(negedge clk);
    end
    if (resp_valid) n++;
    if (req_ready) rdy_ok = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_valid_cycles", n, 4);
    chk("stall_ready_low", rdy_ok, 1'b1);
    chk("stall_valid_drop", resp_valid, 1'b0);
    chk("wstore_we_cnt", we_cnt, w0 + 1);
    chk("wstore_mem", mem[16'hFFFF], 16'hBEEF);

    // Reset during RMW_RD aborts the byte store
    w0 = we_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_hi = 1'b0;
    req_addr = 16'h0200; req_wdata = 16'h0077;
    @(negedge clk);
    chk("abort_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_resp_valid", resp_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_no_we", we_cnt, w0);
    chk("abort_no_resp", resp_cnt, r0);
    chk("abort_mem", mem[16'h0200], 16'h0200);

    // Back-to-back load then store with req_valid held high
    r0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_hi = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0003; req_wdata = 16'h0;
    @(negedge clk);
    chk("b2b_accept1", req_ready, 1'b1);
    exp_q.push_back(16'h0003);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 16'h0004; req_wdata = 16'h1234;
    busy = 0;
    @(negedge clk);
    while (!req_ready && busy < 50) begin busy++; @(negedge clk); end
    chk("b2b_busy_cycles", busy, 2);
    chk("b2b_first_done", resp_cnt, r0 + 1);
    exp_q.push_back(16'h0000);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_both_done", resp_cnt, r0 + 2);
    chk("b2b_mem", mem[16'h0004], 16'h1234);
    chk("b2b_load_untouched", mem[16'h0003], 16'h0003);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
